bcd_para_binario: RTL and testbench
===================================

BCD_PARA_BINARIO -- requirements
Module: bcd_para_binario

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports as follows.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 iniciar  input  1  start request, sampled on the rising edge of clock.
REQ-005 dezenaMilhar, unidadeMilhar, centena, dezena, unidade  input  4 each  BCD digits, most significant first.
REQ-006 binario  output  16  conversion result, registered.
REQ-007 pronto  output  1  one-cycle pulse marking a valid binario.
REQ-008 ocupado  output  1  high while a conversion is in progress.
REQ-009 erro  output  1  registered error flag, updated with pronto.

Function
REQ-010 The block SHALL implement a three-state FSM: OCIOSO, CONVERTE, FIM.
REQ-011 In OCIOSO with iniciar=1 at an edge, the block SHALL do all of the following at that edge:
- capture the 20 input bits into a shift register;
- clear a 17-bit accumulator and a 5-bit iteration counter;
- enter CONVERTE.
REQ-012 Each CONVERTE cycle SHALL perform one reverse double-dabble step:
- shift the 20-bit BCD register right by 1 into the accumulator MSB, with the accumulator also shifting right;
- then subtract 3 from every BCD nibble whose value is 8 or more.
REQ-013 After exactly 17 CONVERTE cycles, the block SHALL enter FIM, which lasts one cycle and then returns to OCIOSO.
REQ-014 binario and erro SHALL update at the edge entering FIM.
REQ-015 pronto SHALL be 1 only during FIM.
REQ-016 Latency: if iniciar is sampled at edge T0, pronto SHALL be high in the cycle after edge T17 (18 edges including T0).
REQ-017 ocupado SHALL be 1 in CONVERTE and FIM, and 0 in OCIOSO.
REQ-018 iniciar SHALL be ignored in CONVERTE and FIM; an iniciar held continuously SHALL start a new conversion on the first edge back in OCIOSO.
REQ-019 Input digits SHALL be sampled only at the start edge; changes during a conversion SHALL NOT affect the result.
REQ-020 binario SHALL hold its last value in OCIOSO until the next FIM.
REQ-021 Result without error: binario = accumulator[15:0] and erro = 0.

Reset
REQ-022 When reset=1, the block SHALL asynchronously set: FSM=OCIOSO, binario=0, pronto=0, ocupado=0, erro=0, counter=0, and clear all internal registers.
REQ-023 A reset asserted mid-conversion SHALL abort it with no pronto pulse; the first start after release SHALL behave as from power-up.

Configuration
REQ-024 The macro BCD_PARA_BINARIO_VALIDACAO_EN SHALL control input validation.
REQ-025 With BCD_PARA_BINARIO_VALIDACAO_EN defined, the block SHALL validate the captured digits at the start edge:
- if any digit exceeds 9, the result SHALL be erro=1 and binario=0;
- otherwise, if accumulator[16]=1 (value above 65535), the result SHALL be erro=1 and binario=16'hFFFF (saturated);
- a digit error SHALL take priority over overflow;
- latency SHALL be identical in all cases.
REQ-026 Without BCD_PARA_BINARIO_VALIDACAO_EN:
- erro SHALL be constant 0;
- no validation logic SHALL be present;
- binario SHALL be accumulator[15:0] (value modulo 65536);
- results for non-BCD digits are unspecified, but the FSM timing SHALL be unchanged.

Verification
REQ-027 Digits 0,0,0,0,0 plus iniciar -> 18 edges later, pronto=1 for one cycle, binario=16'h0000, erro=0.
REQ-028 Digits 1,2,3,4,5 -> binario=16'h3039, erro=0; ocupado high for exactly 18 cycles.
REQ-029 Digits 6,5,5,3,5 -> binario=16'hFFFF, erro=0.
REQ-030 With the macro, digits 6,5,5,3,6 -> erro=1 and binario=16'hFFFF; digits 0,0,0,4'hA,0 -> erro=1 and binario=16'h0000. Without the macro, 6,5,5,3,6 -> binario=16'h0000, erro=0.
REQ-031 Pulse iniciar with 1,2,3,4,5, then pulse iniciar with 9,9,9,9,9 at cycle 5 -> second start ignored; single pronto with binario=16'h3039.
REQ-032 Assert reset at cycle 8 of a conversion -> all outputs 0 immediately, no pronto; after release, a start with 0,0,0,4,2 -> binario=16'h002A.

Source files
------------

// File: rtl/bcd_para_binario.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_para_binario
//  Purpose  : Sequential five-digit BCD to 16-bit binary converter. It uses
//             the reverse double-dabble algorithm, with one shift/correct
//             step per clock. A conversion lasts 17 CONVERTE cycles, then
//             one FIM cycle.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock          in   1   rising-edge clock for all state
//    reset          in   1   asynchronous, active-high reset
//    iniciar        in   1   start request (honoured only when idle)
//    dezenaMilhar   in   4   BCD digit x10000
//    unidadeMilhar  in   4   BCD digit x1000
//    centena        in   4   BCD digit x100
//    dezena         in   4   BCD digit x10
//    unidade        in   4   BCD digit x1
//    binario        out  16  registered result, held until the next FIM
//    pronto         out  1   single-cycle pulse while binario is fresh
//    ocupado        out  1   high during CONVERTE and FIM
//    erro           out  1   registered error flag, updated with pronto
// ----------------------------------------------------------------------------
//  Build option
//    BCD_PARA_BINARIO_VALIDACAO_EN : when defined, digits above 9 report
//      erro=1 with binario=0. Results above 65535 report erro=1 with
//      binario=16'hFFFF. A digit error has priority over overflow.
//      When undefined, erro is tied to 0 and binario wraps modulo 65536.
// ============================================================================
module bcd_para_binario (
    input  logic        clock,
    input  logic        reset,
    input  logic        iniciar,
    input  logic [3:0]  dezenaMilhar,
    input  logic [3:0]  unidadeMilhar,
    input  logic [3:0]  centena,
    input  logic [3:0]  dezena,
    input  logic [3:0]  unidade,
    output logic [15:0] binario,
    output logic        pronto,
    output logic        ocupado,
    output logic        erro
);

    // 99999 needs 17 bits, so 17 shift steps drain the BCD register
    // completely. The counter reads 16 during the last step.
    localparam logic [4:0] c_ULTIMO_PASSO = 5'd16;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        CONVERTE = 2'd1,
        FIM      = 2'd2
    } estado_t;

    estado_t     r_estado;
    estado_t     w_prox_estado;

    logic [19:0] r_bcd;
    logic [16:0] r_acc;
    logic [4:0]  r_contador;
    logic [15:0] r_binario;

    logic        w_inicio;
    logic        w_ultimo;
    logic [36:0] w_desloc;
    logic [19:0] w_bcd_prox;
    logic [16:0] w_acc_prox;

    // After a right shift, a nibble whose MSB is set has received a bit
    // worth 10/2 = 5 from the digit above it. That bit is encoded as 8, so
    // subtracting 3 restores a valid decimal weight.
    function automatic logic [19:0] corrige_digitos(input logic [19:0] v);
        logic [19:0] res;
        res = v;
        for (int i = 0; i < 5; i++) begin
            if (v[4*i+3]) begin
                res[4*i +: 4] = v[4*i +: 4] - 4'd3;
            end
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // One reverse double-dabble step. The BCD register and the accumulator
    // form a single 37-bit shifter. Its bit 0 falls off the end.
    // ------------------------------------------------------------------
    always_comb begin
        w_desloc   = {r_bcd, r_acc} >> 1;
        w_acc_prox = w_desloc[16:0];
        w_bcd_prox = corrige_digitos(w_desloc[36:17]);
    end

    assign w_inicio = (r_estado == OCIOSO) && iniciar;
    assign w_ultimo = (r_estado == CONVERTE) && (r_contador == c_ULTIMO_PASSO);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado <= OCIOSO;
        end else begin
            r_estado <= w_prox_estado;
        end
    end

    always_comb begin
        w_prox_estado = r_estado;
        pronto        = 1'b0;
        ocupado       = 1'b0;
        case (r_estado)
            OCIOSO: begin
                if (iniciar) begin
                    w_prox_estado = CONVERTE;
                end
            end
            CONVERTE: begin
                ocupado = 1'b1;
                if (r_contador == c_ULTIMO_PASSO) begin
                    w_prox_estado = FIM;
                end
            end
            FIM: begin
                ocupado       = 1'b1;
                pronto        = 1'b1;
                w_prox_estado = OCIOSO;
            end
            default: begin
                w_prox_estado = OCIOSO;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Shift datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_bcd      <= 20'd0;
            r_acc      <= 17'd0;
            r_contador <= 5'd0;
        end else if (w_inicio) begin
            r_bcd      <= {dezenaMilhar, unidadeMilhar, centena, dezena, unidade};
            r_acc      <= 17'd0;
            r_contador <= 5'd0;
        end else if (r_estado == CONVERTE) begin
            r_bcd      <= w_bcd_prox;
            r_acc      <= w_acc_prox;
            r_contador <= r_contador + 5'd1;
        end
    end

    // ------------------------------------------------------------------
    // Result register. It loads from the final step's accumulator on the
    // edge that enters FIM.
    // ------------------------------------------------------------------
`ifdef BCD_PARA_BINARIO_VALIDACAO_EN
    logic r_erro;
    logic r_erro_digito;
    logic w_digito_invalido;

    assign w_digito_invalido = (dezenaMilhar  > 4'd9) || (unidadeMilhar > 4'd9) ||
                               (centena       > 4'd9) || (dezena        > 4'd9) ||
                               (unidade       > 4'd9);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_erro_digito <= 1'b0;
        end else if (w_inicio) begin
            r_erro_digito <= w_digito_invalido;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_binario <= 16'd0;
            r_erro    <= 1'b0;
        end else if (w_ultimo) begin
            if (r_erro_digito) begin
                r_binario <= 16'h0000;
                r_erro    <= 1'b1;
            end else if (w_acc_prox[16]) begin
                r_binario <= 16'hFFFF;
                r_erro    <= 1'b1;
            end else begin
                r_binario <= w_acc_prox[15:0];
                r_erro    <= 1'b0;
            end
        end
    end

    assign erro = r_erro;
`else
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_binario <= 16'd0;
        end else if (w_ultimo) begin
            r_binario <= w_acc_prox[15:0];
        end
    end

    assign erro = 1'b0;
`endif

    assign binario = r_binario;

endmodule
`default_nettype wire

// File: tb/tb_bcd_para_binario.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bcd_para_binario
//  Purpose  : Self-checking bench for bcd_para_binario. It uses randomized
//             digit stimulus checked against an arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_para_binario;

    logic        clock = 1'b0;
    logic        reset;
    logic        iniciar;
    logic [3:0]  dezenaMilhar, unidadeMilhar, centena, dezena, unidade;
    logic [15:0] binario;
    logic        pronto, ocupado, erro;

    int n_checks = 0;
    int n_fail   = 0;

    bcd_para_binario dut (
        .clock         (clock),
        .reset         (reset),
        .iniciar       (iniciar),
        .dezenaMilhar  (dezenaMilhar),
        .unidadeMilhar (unidadeMilhar),
        .centena       (centena),
        .dezena        (dezena),
        .unidade       (unidade),
        .binario       (binario),
        .pronto        (pronto),
        .ocupado       (ocupado),
        .erro          (erro)
    );

    always #5 clock = ~clock;

    // Reference model: decimal value computed with plain arithmetic.
    function automatic void modelo(input logic [19:0] d, output logic [15:0] b, output logic e);
        int v;
        v = int'(d[19:16]) * 10000 + int'(d[15:12]) * 1000 + int'(d[11:8]) * 100
          + int'(d[7:4]) * 10 + int'(d[3:0]);
`ifdef BCD_PARA_BINARIO_VALIDACAO_EN
        if (d[19:16] > 9 || d[15:12] > 9 || d[11:8] > 9 || d[7:4] > 9 || d[3:0] > 9) begin
            b = 16'h0000; e = 1'b1;
        end else if (v > 65535) begin
            b = 16'hFFFF; e = 1'b1;
        end else begin
            b = 16'(v); e = 1'b0;
        end
`else
        b = 16'(v % 65536);
        e = 1'b0;
`endif
    endfunction

    function automatic logic [19:0] digitos_aleatorios();
        logic [19:0] d;
        for (int i = 0; i < 5; i++) begin
`ifdef BCD_PARA_BINARIO_VALIDACAO_EN
            d[4*i +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                      : 4'($urandom_range(0, 9));
`else
            d[4*i +: 4] = 4'($urandom_range(0, 9));
`endif
        end
        return d;
    endfunction

    task automatic poe_digitos(input logic [19:0] d);
        dezenaMilhar  = d[19:16];
        unidadeMilhar = d[15:12];
        centena       = d[11:8];
        dezena        = d[7:4];
        unidade       = d[3:0];
    endtask

    // Starts one conversion and scrambles the digits afterwards. It returns
    // the number of edges from the start edge to pronto (lat, -1 if pronto
    // never came), the cycles with ocupado high, and the result. It returns
    // at the negedge where pronto is seen.
    task automatic run_conv(input logic [19:0] d, output int lat, output int ocup,
                            output logic [15:0] b, output logic e);
        int n;
        @(negedge clock);
        poe_digitos(d);
        iniciar = 1'b1;
        @(posedge clock);
        @(negedge clock);
        iniciar = 1'b0;
        poe_digitos(20'($urandom));
        n = 0; lat = -1; ocup = 0; b = 16'h0; e = 1'b0;
        while (n < 40 && lat < 0) begin
            if (ocupado) ocup++;
            if (pronto) begin
                lat = n; b = binario; e = erro;
            end else begin
                @(negedge clock);
                n++;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; iniciar = 1'b0; poe_digitos(20'h0);
        #1;
        n_checks++;
        if ({binario, pronto, ocupado, erro} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got bin=%h pronto=%b ocupado=%b erro=%b, want all 0",
                     binario, pronto, ocupado, erro);
        end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        n_checks++;
        if ({pronto, ocupado} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_idle: got pronto=%b ocupado=%b, want 0 0", pronto, ocupado);
        end
    endtask

    task automatic test_zero();
        int lat, ocup; logic [15:0] b; logic e;
        run_conv(20'h00000, lat, ocup, b, e);
        n_checks++;
        if (lat !== 17) begin n_fail++; $display("FAIL zero_latency: got %0d want 17", lat); end
        n_checks++;
        if (b !== 16'h0000 || e !== 1'b0) begin
            n_fail++; $display("FAIL zero_result: got bin=%h erro=%b want 0000 0", b, e);
        end
        @(negedge clock);
        n_checks++;
        if (pronto !== 1'b0 || ocupado !== 1'b0 || binario !== 16'h0000) begin
            n_fail++;
            $display("FAIL zero_pulse: got pronto=%b ocupado=%b bin=%h want 0 0 0000", pronto, ocupado, binario);
        end
    endtask

    task automatic test_known();
        logic [19:0] tab [0:7];
        int          n;
        int lat, ocup; logic [15:0] b, eb; logic e, ee;
        tab[0] = 20'h12345; tab[1] = 20'h65535; tab[2] = 20'h65536; tab[3] = 20'h99999;
        tab[4] = 20'h00001; tab[5] = 20'h10000;
`ifdef BCD_PARA_BINARIO_VALIDACAO_EN
        tab[6] = 20'h000A0; tab[7] = 20'hF9999; n = 8;
`else
        n = 6;
`endif
        for (int i = 0; i < n; i++) begin
            run_conv(tab[i], lat, ocup, b, e);
            modelo(tab[i], eb, ee);
            n_checks++;
            if (b !== eb || e !== ee) begin
                n_fail++;
                $display("FAIL known_%h: got bin=%h erro=%b want bin=%h erro=%b", tab[i], b, e, eb, ee);
            end
            n_checks++;
            if (lat !== 17 || ocup !== 18) begin
                n_fail++;
                $display("FAIL known_timing_%h: got lat=%0d ocupado=%0d want 17 18", tab[i], lat, ocup);
            end
            // binario must hold its value while idle
            repeat (3) @(negedge clock);
            n_checks++;
            if (binario !== eb) begin
                n_fail++; $display("FAIL known_hold_%h: got %h want %h", tab[i], binario, eb);
            end
        end
    endtask

    task automatic test_random();
        logic [19:0] d;
        int lat, ocup; logic [15:0] b, eb; logic e, ee;
        for (int i = 0; i < 25; i++) begin
            d = digitos_aleatorios();
            run_conv(d, lat, ocup, b, e);
            modelo(d, eb, ee);
            n_checks++;
            if (b !== eb || e !== ee || lat !== 17) begin
                n_fail++;
                $display("FAIL random_%h: got bin=%h erro=%b lat=%0d want bin=%h erro=%b lat=17",
                         d, b, e, lat, eb, ee);
            end
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end
    endtask

    task automatic test_ignore_start();
        int n_pronto, lat; logic [15:0] b;
        @(negedge clock);
        poe_digitos(20'h12345);
        iniciar = 1'b1;
        @(posedge clock);
        @(negedge clock);
        iniciar = 1'b0;
        n_pronto = 0; lat = -1; b = 16'h0;
        for (int n = 0; n < 40; n++) begin
            if (n == 4) begin poe_digitos(20'h99999); iniciar = 1'b1; end
            if (n == 5) iniciar = 1'b0;
            if (pronto) begin
                n_pronto++;
                if (lat < 0) begin lat = n; b = binario; end
            end
            @(negedge clock);
        end
        n_checks++;
        if (n_pronto !== 1 || lat !== 17) begin
            n_fail++; $display("FAIL ignore_start_pulses: got %0d pulses lat=%0d want 1 17", n_pronto, lat);
        end
        n_checks++;
        if (b !== 16'h3039) begin
            n_fail++; $display("FAIL ignore_start_value: got %h want 3039", b);
        end
    endtask

    task automatic test_reset_mid();
        int n_pronto, lat, ocup; logic [15:0] b; logic e;
        @(negedge clock);
        poe_digitos(20'h12345);
        iniciar = 1'b1;
        @(posedge clock);
        @(negedge clock);
        iniciar = 1'b0;
        repeat (8) @(negedge clock);
        reset = 1'b1;
        #1;
        n_checks++;
        if ({binario, pronto, ocupado, erro} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got bin=%h pronto=%b ocupado=%b erro=%b want all 0",
                     binario, pronto, ocupado, erro);
        end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        n_pronto = 0;
        for (int n = 0; n < 20; n++) begin
            if (pronto || ocupado) n_pronto++;
            @(negedge clock);
        end
        n_checks++;
        if (n_pronto !== 0) begin
            n_fail++; $display("FAIL reset_mid_abort: got %0d busy/pronto cycles want 0", n_pronto);
        end
        run_conv(20'h00042, lat, ocup, b, e);
        n_checks++;
        if (b !== 16'h002A || e !== 1'b0 || lat !== 17) begin
            n_fail++;
            $display("FAIL reset_mid_restart: got bin=%h erro=%b lat=%0d want 002A 0 17", b, e, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] da, db;
        logic [15:0] ba, bb, ea_b, eb_b;
        logic        ea_e, eb_e, idle18, idle37;
        int          p1, p2;
        da = digitos_aleatorios(); db = digitos_aleatorios();
        modelo(da, ea_b, ea_e); modelo(db, eb_b, eb_e);
        @(negedge clock);
        poe_digitos(da);
        iniciar = 1'b1;
        @(posedge clock);
        @(negedge clock);
        p1 = -1; p2 = -1; ba = 16'h0; bb = 16'h0; idle18 = 1'b1; idle37 = 1'b1;
        for (int n = 0; n < 45; n++) begin
            if (pronto && p1 < 0) begin
                p1 = n; ba = binario; poe_digitos(db);
            end else if (pronto && p2 < 0) begin
                p2 = n; bb = binario;
            end
            if (n == 18) idle18 = ocupado;
            if (n == 37) begin idle37 = ocupado; iniciar = 1'b0; end
            @(negedge clock);
        end
        n_checks++;
        if (p1 !== 17 || p2 !== 36 || idle18 !== 1'b0 || idle37 !== 1'b0) begin
            n_fail++;
            $display("FAIL back_to_back_timing: got p1=%0d p2=%0d idle18=%b idle37=%b want 17 36 0 0",
                     p1, p2, idle18, idle37);
        end
        n_checks++;
        if (ba !== ea_b || bb !== eb_b) begin
            n_fail++;
            $display("FAIL back_to_back_values: got %h %h want %h %h", ba, bb, ea_b, eb_b);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_zero();
        test_known();
        test_random();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
